exc_commit_ctrl: RTL and testbench
==================================

Name: exc_commit_ctrl

Overview:
- Sequences commit of a detected exception or ERET: latches the exception record, drains outstanding data-bus transactions, flushes the pipeline, then redirects fetch.
- Sits between the MEM-stage exception resolver, CP0, the data-bus interface and the fetch stage.
- Guarantees exactly one CP0 update and one fetch redirect per accepted event.

Parameters:
- EXCT_W, 4, width of exception type code; value 0 = no exception.
- ERET_CODE, 4'hE, type code that denotes ERET.
- MAX_OUTS, 4, max outstanding data-bus transactions tracked (counter width clog2(MAX_OUTS+1)).
- FLUSH_CYCLES, 2, cycles flush_o is held (1..15).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- exc_flag_i  in  1  exception/ERET present at commit this cycle
- exc_type_i  in  EXCT_W  exception type code
- exc_pc_i  in  32  PC of the faulting instruction
- exc_bd_i  in  1  faulting instruction is in a branch delay slot
- exc_baddr_i  in  32  bad virtual address
- flush_pc_i  in  32  target PC from the resolver
- mem_req_i  in  1  data-bus request accepted this cycle
- mem_done_i  in  1  data-bus response returned this cycle
- redirect_ack_i  in  1  fetch accepts the redirect
- bev_i  in  1  CP0 Status.BEV (used only with the optional feature)
- busy_o  out  1  controller not IDLE
- stall_o  out  1  freeze pipeline stages upstream of commit
- flush_o  out  1  kill all in-flight instructions
- cp0_we_o  out  1  one-cycle CP0 exception-update strobe
- cp0_type_o  out  EXCT_W  latched type
- cp0_epc_o  out  32  EPC value
- cp0_bd_o  out  1  latched BD
- cp0_baddr_o  out  32  latched BadVAddr
- eret_o  out  1  one-cycle pulse (with cp0_we_o) when the event is ERET
- redirect_valid_o  out  1  redirect request to fetch
- redirect_pc_o  out  32  redirect target

Behaviour:
- Reset: every output is 0, state IDLE, outstanding counter 0, FLUSH_CYCLES counter 0. Reset asserted mid-sequence aborts to IDLE with no redirect.
- Outstanding counter:
  - mem_req_i alone increments; mem_done_i alone decrements; both together leave it unchanged.
  - Saturates at MAX_OUTS. A done while the counter is 0 is ignored.
  - The counter runs in every state.
- IDLE:
  - If exc_flag_i=1 and exc_type_i!=0, capture type, pc, bd, baddr and target on the same edge.
  - Next cycle: cp0_we_o=1 for exactly one cycle; eret_o=1 for that cycle if type==ERET_CODE.
  - cp0_epc_o = bd ? pc-4 : pc (32-bit wrap).
  - Next state is DRAIN. exc_flag_i with type 0 is ignored.
- DRAIN:
  - stall_o=1.
  - Leave when the next counter value is 0 (a done in the same cycle as count==1 qualifies). Entering DRAIN with count 0 leaves after 1 cycle.
  - Next state is FLUSH.
- FLUSH:
  - flush_o=1 and stall_o=1 for exactly FLUSH_CYCLES consecutive cycles.
  - Next state is REDIRECT.
- REDIRECT:
  - redirect_valid_o=1, redirect_pc_o = latched target, stall_o=1.
  - Values are held stable until redirect_ack_i=1 is sampled; ack may arrive in the first REDIRECT cycle.
  - On ack, go to IDLE; redirect_valid_o drops the next cycle.
- While busy_o=1, exc_flag_i is ignored; the resolver keeps it asserted until it is flushed.
- busy_o=1 in all states except IDLE. cp0_* data outputs hold their latched values until the next capture.
- Minimum sequence with count 0, FLUSH_CYCLES=2 and immediate ack: capture edge, 1 DRAIN cycle, 2 FLUSH cycles, 1 REDIRECT cycle, then IDLE.

Optional Feature:
- EXC_BEV_VEC_EN defined: for non-ERET events the target is computed internally, ignoring flush_pc_i.
  - bev_i=1: 32'hBFC0_0380.
  - bev_i=0: 32'h8000_0180.
  - bev_i is sampled at the capture edge.
  - ERET still uses flush_pc_i.
- EXC_BEV_VEC_EN undefined: target = flush_pc_i always; bev_i is unused.

Test Plan:
- Idle, count 0, exc type 1, pc=32'hBFC0_0100, bd=0, flush_pc=32'hBFC0_0380 -> cp0_we_o one pulse, epc=32'hBFC0_0100; flush_o 2 cycles; redirect_pc_o=32'hBFC0_0380 until ack.
- bd=1, pc=32'h8000_1004 -> cp0_epc_o=32'h8000_1000, cp0_bd_o=1.
- 3 mem_req pulses, then exc, then mem_done on 3 later cycles -> flush_o rises only the cycle after the 3rd done. Also drive req+done in the same cycle -> count unchanged.
- Type=ERET_CODE, flush_pc=32'h8000_2000 -> eret_o pulse coincident with cp0_we_o; redirect_pc_o=32'h8000_2000.
- redirect_ack_i withheld 5 cycles -> redirect_valid_o/pc stable for 6 cycles; a second exc_flag_i during the sequence produces no second cp0_we_o.
- rst asserted during FLUSH -> all outputs 0 asynchronously, IDLE, no redirect. With EXC_BEV_VEC_EN and bev_i=0, a type-1 exc -> redirect_pc_o=32'h8000_0180.

Source files
------------

// File: rtl/exc_commit_ctrl.sv
// -----------------------------------------------------------------------------
// exc_commit_ctrl
//
// Sequences the commit of an exception or ERET. The event record is captured
// on the first edge, CP0 is updated once, outstanding data-bus transactions
// are drained, the pipeline is flushed for FLUSH_CYCLES cycles, and then a
// single redirect is offered to fetch and held until it is acknowledged.
//
// Optional feature (compile-time macro EXC_BEV_VEC_EN):
//   When defined, non-ERET events redirect to the architectural exception
//   vector selected by bev_i, which is sampled at the capture edge. ERET
//   still uses flush_pc_i. When undefined, the redirect target is always
//   flush_pc_i and bev_i is unused.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   exc_flag_i          exception/ERET present at commit this cycle
//   exc_type_i          exception type code (0 = none)
//   exc_pc_i            PC of the faulting instruction
//   exc_bd_i            faulting instruction sits in a branch delay slot
//   exc_baddr_i         bad virtual address
//   flush_pc_i          redirect target from the resolver
//   mem_req_i           data-bus request accepted this cycle
//   mem_done_i          data-bus response returned this cycle
//   redirect_ack_i      fetch accepts the redirect
//   bev_i               CP0 Status.BEV (optional feature only)
//   busy_o              controller not idle
//   stall_o             freeze stages upstream of commit
//   flush_o             kill all in-flight instructions
//   cp0_we_o            one-cycle CP0 exception-update strobe
//   cp0_type_o          latched type code
//   cp0_epc_o           EPC (PC, or PC-4 when in a delay slot)
//   cp0_bd_o            latched BD flag
//   cp0_baddr_o         latched BadVAddr
//   eret_o              one-cycle pulse alongside cp0_we_o for ERET
//   redirect_valid_o    redirect request to fetch
//   redirect_pc_o       redirect target
// -----------------------------------------------------------------------------
module exc_commit_ctrl #(
    parameter int unsigned       EXCT_W       = 4,
    parameter logic [EXCT_W-1:0] ERET_CODE    = EXCT_W'(4'hE),
    parameter int unsigned       MAX_OUTS     = 4,
    parameter int unsigned       FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exc_flag_i,
    input  logic [EXCT_W-1:0] exc_type_i,
    input  logic [31:0]       exc_pc_i,
    input  logic              exc_bd_i,
    input  logic [31:0]       exc_baddr_i,
    input  logic [31:0]       flush_pc_i,
    input  logic              mem_req_i,
    input  logic              mem_done_i,
    input  logic              redirect_ack_i,
    input  logic              bev_i,
    output logic              busy_o,
    output logic              stall_o,
    output logic              flush_o,
    output logic              cp0_we_o,
    output logic [EXCT_W-1:0] cp0_type_o,
    output logic [31:0]       cp0_epc_o,
    output logic              cp0_bd_o,
    output logic [31:0]       cp0_baddr_o,
    output logic              eret_o,
    output logic              redirect_valid_o,
    output logic [31:0]       redirect_pc_o
);

    localparam int unsigned      CNT_W      = $clog2(MAX_OUTS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(MAX_OUTS);
    localparam logic [3:0]       FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StDrain,
        StFlush,
        StRedirect
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  outs_q, outs_d;
    logic [3:0]        flush_cnt_q, flush_cnt_d;
    logic              capture;
    logic              is_eret;
    logic [31:0]       target_sel;

    logic              cp0_we_q;
    logic              eret_q;
    logic [EXCT_W-1:0] type_q;
    logic [31:0]       epc_q;
    logic              bd_q;
    logic [31:0]       baddr_q;
    logic [31:0]       target_q;

    assign is_eret = (exc_type_i == ERET_CODE);

`ifdef EXC_BEV_VEC_EN
    always_comb begin
        target_sel = flush_pc_i;
        if (!is_eret) begin
            target_sel = bev_i ? 32'hBFC0_0380 : 32'h8000_0180;
        end
    end
`else
    logic unused_bev;
    assign unused_bev = bev_i;
    assign target_sel = flush_pc_i;
`endif

    // Outstanding data-bus transactions; runs in every state. Simultaneous
    // request and response cancel, the count saturates at MAX_OUTS, and a
    // response with nothing outstanding is dropped.
    always_comb begin
        outs_d = outs_q;
        if (mem_req_i && !mem_done_i) begin
            if (outs_q != CNT_MAX) begin
                outs_d = outs_q + CNT_W'(1);
            end
        end else if (mem_done_i && !mem_req_i) begin
            if (outs_q != '0) begin
                outs_d = outs_q - CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        capture     = 1'b0;
        case (state_q)
            StIdle: begin
                if (exc_flag_i && (exc_type_i != '0)) begin
                    capture = 1'b1;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // Look at the next count so a response arriving with one
                // transaction left ends the drain this cycle.
                if (outs_d == '0) begin
                    state_d     = StFlush;
                    flush_cnt_d = '0;
                end
            end
            StFlush: begin
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d     = StRedirect;
                    flush_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q + 4'd1;
                end
            end
            StRedirect: begin
                if (redirect_ack_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d     = StIdle;
                flush_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            outs_q      <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            outs_q      <= outs_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Event record. The strobes are registered so CP0 sees them the cycle
    // after capture, together with the already-latched data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cp0_we_q <= 1'b0;
            eret_q   <= 1'b0;
            type_q   <= '0;
            epc_q    <= '0;
            bd_q     <= 1'b0;
            baddr_q  <= '0;
            target_q <= '0;
        end else begin
            cp0_we_q <= capture;
            eret_q   <= capture && is_eret;
            if (capture) begin
                type_q   <= exc_type_i;
                epc_q    <= exc_bd_i ? (exc_pc_i - 32'd4) : exc_pc_i;
                bd_q     <= exc_bd_i;
                baddr_q  <= exc_baddr_i;
                target_q <= target_sel;
            end
        end
    end

    always_comb begin
        busy_o           = (state_q != StIdle);
        stall_o          = (state_q != StIdle);
        flush_o          = (state_q == StFlush);
        redirect_valid_o = (state_q == StRedirect);
        redirect_pc_o    = (state_q == StRedirect) ? target_q : 32'd0;
        cp0_we_o         = cp0_we_q;
        eret_o           = eret_q;
        cp0_type_o       = type_q;
        cp0_epc_o        = epc_q;
        cp0_bd_o         = bd_q;
        cp0_baddr_o      = baddr_q;
    end

endmodule

// File: tb/tb_exc_commit_ctrl.sv
module tb_exc_commit_ctrl;

    localparam int unsigned FLUSH_CYCLES = 2;
    localparam logic [3:0]  ERET         = 4'hE;

    logic        clk;
    logic        rst;
    logic        exc_flag;
    logic [3:0]  exc_type;
    logic [31:0] exc_pc;
    logic        exc_bd;
    logic [31:0] exc_baddr;
    logic [31:0] flush_pc;
    logic        mem_req;
    logic        mem_done;
    logic        redirect_ack;
    logic        bev;
    logic        busy_o;
    logic        stall_o;
    logic        flush_o;
    logic        cp0_we_o;
    logic [3:0]  cp0_type_o;
    logic [31:0] cp0_epc_o;
    logic        cp0_bd_o;
    logic [31:0] cp0_baddr_o;
    logic        eret_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;

    exc_commit_ctrl #(
        .EXCT_W       (4),
        .ERET_CODE    (4'hE),
        .MAX_OUTS     (4),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .exc_flag_i       (exc_flag),
        .exc_type_i       (exc_type),
        .exc_pc_i         (exc_pc),
        .exc_bd_i         (exc_bd),
        .exc_baddr_i      (exc_baddr),
        .flush_pc_i       (flush_pc),
        .mem_req_i        (mem_req),
        .mem_done_i       (mem_done),
        .redirect_ack_i   (redirect_ack),
        .bev_i            (bev),
        .busy_o           (busy_o),
        .stall_o          (stall_o),
        .flush_o          (flush_o),
        .cp0_we_o         (cp0_we_o),
        .cp0_type_o       (cp0_type_o),
        .cp0_epc_o        (cp0_epc_o),
        .cp0_bd_o         (cp0_bd_o),
        .cp0_baddr_o      (cp0_baddr_o),
        .eret_o           (eret_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  typ;
        logic [31:0] epc;
        logic        bd;
        logic [31:0] baddr;
        logic        eret;
        logic [31:0] target;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec;
    int          n_err;
    logic [31:0] cur_target;
    int          waited;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_target(input logic [3:0] t, input logic [31:0] fpc,
                                                 input logic b);
        logic [31:0] vec;
        vec = b ? 32'hBFC0_0380 : 32'h8000_0180;
`ifdef EXC_BEV_VEC_EN
        if (t != ERET) return vec;
`else
        if (t == ERET && vec == 32'h0) return 32'h0;
`endif
        return fpc;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk1({tag, "_busy"}, busy_o, 1'b0);
        chk1({tag, "_stall"}, stall_o, 1'b0);
        chk1({tag, "_flush"}, flush_o, 1'b0);
        chk1({tag, "_we"}, cp0_we_o, 1'b0);
        chk32({tag, "_type"}, {28'd0, cp0_type_o}, 32'd0);
        chk32({tag, "_epc"}, cp0_epc_o, 32'd0);
        chk1({tag, "_bd"}, cp0_bd_o, 1'b0);
        chk32({tag, "_baddr"}, cp0_baddr_o, 32'd0);
        chk1({tag, "_eret"}, eret_o, 1'b0);
        chk1({tag, "_rv"}, redirect_valid_o, 1'b0);
        chk32({tag, "_rpc"}, redirect_pc_o, 32'd0);
    endtask

    // Drive an event at a negedge, push the expected record, then check the
    // CP0 strobe cycle against the popped record. Leaves the bench at the
    // negedge of the strobe cycle (first DRAIN cycle).
    task automatic start_event(input logic [3:0] t, input logic [31:0] pc, input logic bd,
                               input logic [31:0] ba, input logic [31:0] fpc, input logic b,
                               input logic hold);
        exp_t e;
        exc_flag  = 1'b1;
        exc_type  = t;
        exc_pc    = pc;
        exc_bd    = bd;
        exc_baddr = ba;
        flush_pc  = fpc;
        bev       = b;
        e.typ     = t;
        e.epc     = bd ? (pc - 32'd4) : pc;
        e.bd      = bd;
        e.baddr   = ba;
        e.eret    = (t == ERET);
        e.target  = model_target(t, fpc, b);
        sb_q.push_back(e);
        tick();
        if (!hold) exc_flag = 1'b0;
        // Scramble the record inputs; the DUT must use its latched copy.
        exc_pc    = 32'hDEAD_BEEF;
        exc_baddr = 32'hCAFE_F00D;
        flush_pc  = 32'h0BAD_0BAD;
        exc_bd    = ~bd;
        bev       = ~b;
        e = sb_q.pop_front();
        chk1("cp0_we", cp0_we_o, 1'b1);
        chk1("eret", eret_o, e.eret);
        chk32("cp0_type", {28'd0, cp0_type_o}, {28'd0, e.typ});
        chk32("cp0_epc", cp0_epc_o, e.epc);
        chk1("cp0_bd", cp0_bd_o, e.bd);
        chk32("cp0_baddr", cp0_baddr_o, e.baddr);
        chk1("drain_busy", busy_o, 1'b1);
        chk1("drain_stall", stall_o, 1'b1);
        chk1("drain_flush", flush_o, 1'b0);
        cur_target = e.target;
    endtask

    // Wait (bounded) for flush, measure it, then check the redirect is held
    // stable for ack_delay extra cycles before acking it.
    task automatic finish_event(input int ack_delay, output int wait_cycles);
        int fc;
        int extra_we;
        wait_cycles = 0;
        extra_we    = 0;
        while (!flush_o && wait_cycles < 50) begin
            tick();
            wait_cycles++;
            if (cp0_we_o) extra_we++;
        end
        chk1("flush_seen", flush_o, 1'b1);
        exc_flag = 1'b0;
        fc = 0;
        while (flush_o && fc < 20) begin
            fc++;
            if (cp0_we_o) extra_we++;
            chk1("flush_stall", stall_o, 1'b1);
            chk1("flush_rv", redirect_valid_o, 1'b0);
            tick();
        end
        chk32("flush_len", fc, FLUSH_CYCLES);
        chk1("rv", redirect_valid_o, 1'b1);
        chk32("rpc", redirect_pc_o, cur_target);
        chk1("redir_stall", stall_o, 1'b1);
        for (int i = 0; i < ack_delay; i++) begin
            tick();
            if (cp0_we_o) extra_we++;
            chk1("rv_hold", redirect_valid_o, 1'b1);
            chk32("rpc_hold", redirect_pc_o, cur_target);
        end
        redirect_ack = 1'b1;
        tick();
        redirect_ack = 1'b0;
        chk1("rv_drop", redirect_valid_o, 1'b0);
        chk1("idle_busy", busy_o, 1'b0);
        chk1("idle_stall", stall_o, 1'b0);
        chk32("single_we", extra_we, 0);
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        rst          = 1'b0;
        exc_flag     = 1'b0;
        exc_type     = 4'd0;
        exc_pc       = 32'd0;
        exc_bd       = 1'b0;
        exc_baddr    = 32'd0;
        flush_pc     = 32'd0;
        mem_req      = 1'b0;
        mem_done     = 1'b0;
        redirect_ack = 1'b0;
        bev          = 1'b1;
        #1 rst = 1'b1;
        tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // Type 0 with flag is ignored.
        exc_flag = 1'b1;
        exc_type = 4'd0;
        tick();
        exc_flag = 1'b0;
        chk1("type0_busy", busy_o, 1'b0);
        chk1("type0_we", cp0_we_o, 1'b0);
        tick();

        // Basic exception, count 0, minimum sequence.
        start_event(4'd1, 32'hBFC0_0100, 1'b0, 32'h0000_1234, 32'hBFC0_0380, 1'b1, 1'b0);
        finish_event(0, waited);
        chk32("min_drain", waited, 1);
        chk32("hold_epc", cp0_epc_o, 32'hBFC0_0100);

        // Branch delay slot.
        start_event(4'd4, 32'h8000_1004, 1'b1, 32'h8000_1010, 32'h8000_0180, 1'b1, 1'b0);
        finish_event(0, waited);
        chk32("bd_epc_hold", cp0_epc_o, 32'h8000_1000);
        chk1("bd_hold", cp0_bd_o, 1'b1);

        // Response with nothing outstanding is dropped, then 3 requests.
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        mem_req  = 1'b1;
        tick();
        tick();
        tick();
        mem_req = 1'b0;
        start_event(4'd2, 32'h8000_0400, 1'b0, 32'h0, 32'h8000_0500, 1'b1, 1'b0);
        mem_done = 1'b1;                      // 3 -> 2
        tick();
        chk1("drain3_a", flush_o, 1'b0);
        mem_req = 1'b1;                       // req+done: stays 2
        tick();
        chk1("drain3_b", flush_o, 1'b0);
        mem_req = 1'b0;                       // 2 -> 1
        tick();
        chk1("drain3_c", flush_o, 1'b0);
        mem_done = 1'b0;
        tick();
        chk1("drain3_d", flush_o, 1'b0);
        mem_done = 1'b1;                      // 1 -> 0, leave drain
        tick();
        mem_done = 1'b0;
        chk1("drain3_flush", flush_o, 1'b1);
        finish_event(0, waited);
        chk32("drain3_wait", waited, 0);

        // Saturation: 6 requests count as 4.
        mem_req = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        mem_req = 1'b0;
        start_event(4'd3, 32'h8000_0600, 1'b0, 32'h0, 32'h8000_0700, 1'b1, 1'b0);
        mem_done = 1'b1;
        tick();
        chk1("sat_a", flush_o, 1'b0);
        tick();
        chk1("sat_b", flush_o, 1'b0);
        tick();
        chk1("sat_c", flush_o, 1'b0);
        tick();
        mem_done = 1'b0;
        chk1("sat_flush", flush_o, 1'b1);
        finish_event(0, waited);
        chk32("sat_wait", waited, 0);

        // ERET.
        start_event(ERET, 32'h8000_0200, 1'b0, 32'h0, 32'h8000_2000, 1'b1, 1'b0);
        finish_event(0, waited);

        // Delayed ack with the flag held high throughout.
        start_event(4'd5, 32'h8000_3000, 1'b0, 32'h8000_3333, 32'h8000_4000, 1'b1, 1'b1);
        finish_event(5, waited);

        // BEV=0 exception; vector applies only with the optional feature.
        start_event(4'd1, 32'h8000_5000, 1'b0, 32'h0, 32'h1234_5670, 1'b0, 1'b0);
        finish_event(0, waited);

        // Reset in the second FLUSH cycle.
        start_event(4'd6, 32'h8000_6000, 1'b1, 32'h8000_6666, 32'h8000_7000, 1'b1, 1'b0);
        waited = 0;
        while (!flush_o && waited < 50) begin
            tick();
            waited++;
        end
        chk1("rst_flush_seen", flush_o, 1'b1);
        tick();
        #2 rst = 1'b1;
        #1 chk_all_zero("async_rst");
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("post_rst_rv", redirect_valid_o, 1'b0);
            chk1("post_rst_busy", busy_o, 1'b0);
        end

        // Recovery after reset.
        start_event(4'd7, 32'h8000_8000, 1'b0, 32'h0, 32'h8000_9000, 1'b1, 1'b0);
        finish_event(1, waited);
        chk32("rec_wait", waited, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

endmodule
